// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill initiator: issues a line request, writes streamed
// beats into the data array, flags the critical word, then tears down the valid/ready handshake.
module icache_refill_ctrl #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ready,
  output logic              sysbus_o_ic_refill_valid,
  output logic [ADDR_W-1:0] sysbus_o_ic_refill_addr,
  input  logic              sysbus_i_ic_refill_valid,
  input  logic [ADDR_W-1:0] sysbus_i_ic_refill_addr,
  input  logic [31:0]       sysbus_i_ic_refill_data,
  input  logic              sysbus_i_ic_refill_ready,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [31:0]       fill_data,
  output logic              crit_valid,
  output logic              fill_done,
  output logic [ADDR_W-1:0] fill_line_addr,
  output logic              busy,
  output logic              err
);
  localparam int CNT_W = $clog2(LINE_WORDS) + 1;
  localparam int OFF_W = $clog2(LINE_WORDS) + 2;

  typedef enum logic [1:0] {IDLE, REQ, STREAM, ACK} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] base, exp_addr;
  logic [ADDR_W-3:0] crit_word;
  logic              in_xfer, accept, full, beat_ok, beat_bad, short_line;
  logic              unused_byte_off;

  // The byte offset inside the missed word never affects the refill.
  assign unused_byte_off = ^miss_addr[1:0];

  assign miss_ready = (state == IDLE) && !sysbus_i_ic_refill_ready;
  assign accept     = miss_valid && miss_ready;
  assign in_xfer    = (state == REQ) || (state == STREAM);
  assign full       = (cnt == CNT_W'(LINE_WORDS));
  assign exp_addr   = base + (ADDR_W'(cnt) << 2);

  // Ready wins over a coincident beat, so such a beat is dropped as an error.
  assign beat_ok    = in_xfer && sysbus_i_ic_refill_valid && !sysbus_i_ic_refill_ready &&
                      !full && (sysbus_i_ic_refill_addr == exp_addr);
  assign beat_bad   = in_xfer && sysbus_i_ic_refill_valid && !beat_ok;
  assign short_line = in_xfer && sysbus_i_ic_refill_ready && !full;

  assign busy                    = (state != IDLE);
  assign sysbus_o_ic_refill_addr = base;
  assign fill_line_addr          = base;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ:     if (sysbus_i_ic_refill_ready) state_nxt = ACK;
               else if (sysbus_i_ic_refill_valid) state_nxt = STREAM;
      STREAM:  if (sysbus_i_ic_refill_ready) state_nxt = ACK;
      ACK:     if (!sysbus_i_ic_refill_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                    <= IDLE;
      sysbus_o_ic_refill_valid <= 1'b0;
    end else begin
      state                    <= state_nxt;
      sysbus_o_ic_refill_valid <= (state_nxt == REQ) || (state_nxt == STREAM);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base       <= '0;
      crit_word  <= '0;
      cnt        <= '0;
      fill_we    <= 1'b0;
      fill_addr  <= '0;
      fill_data  <= '0;
      crit_valid <= 1'b0;
      fill_done  <= 1'b0;
      err        <= 1'b0;
    end else begin
      fill_we    <= beat_ok;
      crit_valid <= beat_ok && (exp_addr[ADDR_W-1:2] == crit_word);
      fill_done  <= in_xfer && sysbus_i_ic_refill_ready;
      if (beat_bad || short_line) err <= 1'b1;
      if (accept) begin
        base      <= {miss_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
        crit_word <= miss_addr[ADDR_W-1:2];
        cnt       <= '0;
      end else if (beat_ok) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (beat_ok) begin
        fill_addr <= sysbus_i_ic_refill_addr;
        fill_data <= sysbus_i_ic_refill_data;
      end
    end
  end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed and randomized refills against a line-level reference model.
module tb_icache_refill_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        miss_valid = 1'b0, miss_ready;
  logic [31:0] miss_addr = '0;
  logic        o_valid;
  logic [31:0] o_addr;
  logic        i_valid = 1'b0, i_ready = 1'b0;
  logic [31:0] i_addr = '0, i_data = '0;
  logic        fill_we, crit_valid, fill_done, busy, err;
  logic [31:0] fill_addr, fill_data, fill_line_addr;

  icache_refill_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .sysbus_o_ic_refill_valid(o_valid), .sysbus_o_ic_refill_addr(o_addr),
    .sysbus_i_ic_refill_valid(i_valid), .sysbus_i_ic_refill_addr(i_addr),
    .sysbus_i_ic_refill_data(i_data), .sysbus_i_ic_refill_ready(i_ready),
    .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data),
    .crit_valid(crit_valid), .fill_done(fill_done), .fill_line_addr(fill_line_addr),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  bit model_err = 1'b0;

  // Observed activity per transaction, stamped with the cycle it occupies.
  logic [31:0] wa[$], wd[$];
  bit          wc[$];
  int          wcyc[$];
  int          dcnt, dcyc, ovc, ov_first, ov_last;
  logic [31:0] dadr;

  always @(negedge clk) begin
    #2;
    if (fill_we) begin
      wa.push_back(fill_addr); wd.push_back(fill_data);
      wc.push_back(crit_valid); wcyc.push_back(cyc + 1);
    end
    if (fill_done) begin
      dcnt++; dcyc = cyc + 1; dadr = fill_line_addr;
    end
    if (o_valid) begin
      if (ovc == 0) ov_first = cyc + 1;
      ov_last = cyc + 1;
      ovc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wa.delete(); wd.delete(); wc.delete(); wcyc.delete();
    dcnt = 0; dcyc = 0; dadr = '0; ovc = 0; ov_first = 0; ov_last = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_err = 1'b0;
  endtask

  // Reset in the middle of a stream while the responder still holds ready.
  task automatic reset_mid();
    @(negedge clk); i_valid = 1'b0; i_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_miss_ready", miss_ready, 0);
    model_err = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    miss_valid = 1'b1; miss_addr = 32'h0000_0440;
    repeat (4) begin
      @(negedge clk); #1;
      chk("hold_miss_ready", miss_ready, 0);
      chk("hold_busy", busy, 0);
    end
    @(negedge clk); i_ready = 1'b0; miss_valid = 1'b0;
  endtask

  // gap<0: random 0..3 idle cycles before every beat; otherwise fixed gap between beats.
  // bad_idx inserts an off-by-one-word beat ahead of that good beat.
  task automatic run_txn(input logic [31:0] a, input int gap, input int nbeats, input int bad_idx,
                         input int rst_at, input bit has_next, input logic [31:0] next_a,
                         input bit timing, output int acc);
    logic [31:0] base, x;
    logic [31:0] ba[$], bd[$], ea[$], ed[$];
    bit          ec[$];
    bit          got, merr;
    int          n;
    base = a & ~32'h1F;
    for (int i = 0; i < nbeats; i++) begin
      if (i == bad_idx) begin ba.push_back(base + 32'(4*i + 4)); bd.push_back($urandom); end
      ba.push_back(base + 32'(4*i)); bd.push_back($urandom);
    end
    clear_mon();
    miss_valid = 1'b1; miss_addr = a; got = 1'b0; acc = 0;
    for (int t = 0; t < 60; t++) begin
      #1;
      if (miss_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept", got, 1);
    if (!got) begin miss_valid = 1'b0; return; end
    acc = cyc + 1;
    @(negedge clk);
    if (has_next) miss_addr = next_a; else miss_valid = 1'b0;
    #1;
    chk("o_valid_rise", o_valid, 1);
    chk("o_addr", o_addr, base);
    for (int i = 0; i < ba.size(); i++) begin
      n = (gap < 0) ? int'($urandom_range(0, 3)) : ((i == 0) ? 0 : gap);
      repeat (n) begin @(negedge clk); i_valid = 1'b0; end
      @(negedge clk); i_valid = 1'b1; i_addr = ba[i]; i_data = bd[i];
      if (i + 1 == rst_at) begin reset_mid(); return; end
    end
    @(negedge clk); i_valid = 1'b0; i_ready = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (!o_valid) begin got = 1'b1; break; end
    end
    chk("o_valid_fall", got, 1);
    @(negedge clk); i_ready = 1'b0;
    #1 chk("miss_ready_ack", miss_ready, 0);
    @(negedge clk); #3;
    chk("miss_ready_idle", miss_ready, 1);
    chk("busy_idle", busy, 0);

    // Reference: beats must arrive in line order; anything else is dropped and flagged.
    n = 0; merr = model_err;
    for (int i = 0; i < ba.size(); i++) begin
      x = ba[i];
      if (n < 8 && x == base + 32'(4*n)) begin
        ea.push_back(x); ed.push_back(bd[i]); ec.push_back(x[31:2] == a[31:2]); n++;
      end else merr = 1'b1;
    end
    if (n != 8) merr = 1'b1;
    model_err = merr;

    chk("n_writes", wa.size(), ea.size());
    for (int i = 0; i < wa.size() && i < ea.size(); i++) begin
      chk("w_addr", wa[i], ea[i]);
      chk("w_data", wd[i], ed[i]);
      chk("w_crit", wc[i], ec[i]);
    end
    chk("done_cnt", dcnt, 1);
    chk("done_addr", dadr, base);
    chk("err", err, model_err);
    chk("ov_first", ov_first, acc + 1);
    chk("ov_held", ovc, ov_last - ov_first + 1);
    if (timing) begin
      chk("ov_last", ov_last, acc + 10);
      chk("done_cyc", dcyc, acc + 11);
      if (wcyc.size() > 0) begin
        chk("w_first_cyc", wcyc[0], acc + 3);
        chk("w_last_cyc", wcyc[wcyc.size()-1], acc + 10);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc1, acc2, bad, nb;
    logic [31:0] ra;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_o_valid0", o_valid, 0);
    chk("rst_o_addr0", o_addr, 0);
    chk("rst_fill_we", fill_we, 0);
    chk("rst_fill_addr", fill_addr, 0);
    chk("rst_fill_data", fill_data, 0);
    chk("rst_crit", crit_valid, 0);
    chk("rst_done", fill_done, 0);
    chk("rst_line_addr", fill_line_addr, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_err0", err, 0);
    chk("rst_miss_ready0", miss_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_txn(32'h0000_1234, 0, 8, -1, -1, 1'b0, '0, 1'b1, acc1);
    run_txn(32'h0000_5678, 3, 8, -1, -1, 1'b0, '0, 1'b0, acc1);
    run_txn(32'h0000_1234, 0, 8, 1, -1, 1'b0, '0, 1'b0, acc1);
    do_reset();
    run_txn(32'h0000_3010, 0, 5, -1, -1, 1'b0, '0, 1'b0, acc1);
    run_txn(32'h0000_0800, 0, 8, -1, 4, 1'b0, '0, 1'b0, acc1);
    run_txn(32'h0000_0440, 0, 8, -1, -1, 1'b0, '0, 1'b1, acc1);

    run_txn(32'h0000_0100, 0, 8, -1, -1, 1'b1, 32'h0000_2004, 1'b1, acc1);
    run_txn(32'h0000_2004, 0, 8, -1, -1, 1'b0, '0, 1'b1, acc2);
    chk("b2b_accept", acc2, acc1 + 13);

    // A ninth beat after a full line is dropped as an error.
    run_txn(32'h0000_7000, 0, 9, -1, -1, 1'b0, '0, 1'b0, acc1);

    for (int k = 0; k < 10; k++) begin
      if (model_err) do_reset();
      ra  = $urandom;
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      nb  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(3, 9)) : 8;
      run_txn(ra, -1, nb, bad, -1, 1'b0, '0, 1'b0, acc1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
